// File: rtl/regfile_2r1w.sv
// regfile_2r1w: 32 x 32-bit register file, one synchronous write port and two
// combinational read ports, plus a per-register busy scoreboard for the
// multi-cycle (mult/div) stall logic.
//
// Each read port is a column of DATA_W bitwise 32:1 muxes (regfile_mux32),
// one per data bit, all sharing the 5-bit read address as select.
//
// Ports:
//   clock, ctrl_reset_n                 clock, async active-low reset
//   ctrl_writeEnable/writeReg, data_writeReg   write port (r0 writes dropped)
//   ctrl_readRegA/B -> data_readRegA/B   combinational read ports
//   ctrl_markBusy, ctrl_markReg          set busy bit of an issued mult/div dest
//   busy_A, busy_B                       busy bit of each read address
//   busy_any                             OR of all busy bits
//
// Optional build macro: REGFILE_BYPASS_EN enables same-cycle write-to-read
// forwarding on both read ports (data and busy).

// Bitwise 32:1 mux: one data bit selected out of 32 register bits.
module regfile_mux32 (
    input  logic [31:0] in_i,
    input  logic [4:0]  sel_i,
    output logic        out_o
);
    assign out_o = in_i[sel_i];
endmodule

module regfile_2r1w #(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned NUM_REGS = 32   // fixed: matches the 5-bit mux select
) (
    input  logic              clock,
    input  logic              ctrl_reset_n,
    input  logic              ctrl_writeEnable,
    input  logic [4:0]        ctrl_writeReg,
    input  logic [DATA_W-1:0] data_writeReg,
    input  logic [4:0]        ctrl_readRegA,
    input  logic [4:0]        ctrl_readRegB,
    output logic [DATA_W-1:0] data_readRegA,
    output logic [DATA_W-1:0] data_readRegB,
    input  logic              ctrl_markBusy,
    input  logic [4:0]        ctrl_markReg,
    output logic              busy_A,
    output logic              busy_B,
    output logic              busy_any
);
    localparam int unsigned ADDR_W = 5;

    logic [DATA_W-1:0]   reg_q [NUM_REGS];
    logic [NUM_REGS-1:0] busy_q;
    logic [NUM_REGS-1:0] busy_d;
    logic                wr_commit_c;
    logic                mark_c;
    logic [NUM_REGS-1:0] slice_c [DATA_W];
    logic [DATA_W-1:0]   rd_a_c;
    logic [DATA_W-1:0]   rd_b_c;

    // r0 is never written and never marked, so it stays at its reset value 0.
    assign wr_commit_c = ctrl_writeEnable && (ctrl_writeReg != ADDR_W'(0));
    assign mark_c      = ctrl_markBusy && (ctrl_markReg != ADDR_W'(0));

    // Register storage.
    always_ff @(posedge clock or negedge ctrl_reset_n) begin
        if (!ctrl_reset_n) begin
            for (int unsigned r = 0; r < NUM_REGS; r++) begin
                reg_q[r] <= '0;
            end
        end else if (wr_commit_c) begin
            reg_q[ctrl_writeReg] <= data_writeReg;
        end
    end

    // Scoreboard next state: write clears first, so a same-edge mark wins.
    always_comb begin
        busy_d = busy_q;
        if (wr_commit_c) begin
            busy_d[ctrl_writeReg] = 1'b0;
        end
        if (mark_c) begin
            busy_d[ctrl_markReg] = 1'b1;
        end
    end

    always_ff @(posedge clock or negedge ctrl_reset_n) begin
        if (!ctrl_reset_n) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    // Transpose storage into per-bit slices feeding the bitwise muxes.
    always_comb begin
        for (int unsigned b = 0; b < DATA_W; b++) begin
            for (int unsigned r = 0; r < NUM_REGS; r++) begin
                slice_c[b][r] = reg_q[r][b];
            end
        end
    end

    for (genvar b = 0; b < DATA_W; b++) begin : g_bit
        regfile_mux32 u_mux_a (
            .in_i  (slice_c[b]),
            .sel_i (ctrl_readRegA),
            .out_o (rd_a_c[b])
        );
        regfile_mux32 u_mux_b (
            .in_i  (slice_c[b]),
            .sel_i (ctrl_readRegB),
            .out_o (rd_b_c[b])
        );
    end

    assign busy_any = |busy_q;

`ifdef REGFILE_BYPASS_EN
    logic fwd_a_c;
    logic fwd_b_c;

    // Forward write data when a committed write targets the read address;
    // the forwarded register is only busy if it is re-marked on this edge.
    assign fwd_a_c       = wr_commit_c && (ctrl_writeReg == ctrl_readRegA);
    assign fwd_b_c       = wr_commit_c && (ctrl_writeReg == ctrl_readRegB);
    assign data_readRegA = fwd_a_c ? data_writeReg : rd_a_c;
    assign data_readRegB = fwd_b_c ? data_writeReg : rd_b_c;
    assign busy_A = fwd_a_c ? (mark_c && (ctrl_markReg == ctrl_readRegA))
                            : busy_q[ctrl_readRegA];
    assign busy_B = fwd_b_c ? (mark_c && (ctrl_markReg == ctrl_readRegB))
                            : busy_q[ctrl_readRegB];
`else
    assign data_readRegA = rd_a_c;
    assign data_readRegB = rd_b_c;
    assign busy_A        = busy_q[ctrl_readRegA];
    assign busy_B        = busy_q[ctrl_readRegB];
`endif

endmodule

// File: tb/tb_regfile_2r1w.sv
// Self-checking bench for regfile_2r1w: directed steps from the test plan
// followed by a randomized phase, all checked against an array-based model.
module tb_regfile_2r1w;
    logic        clock;
    logic        ctrl_reset_n;
    logic        ctrl_writeEnable;
    logic [4:0]  ctrl_writeReg;
    logic [31:0] data_writeReg;
    logic [4:0]  ctrl_readRegA;
    logic [4:0]  ctrl_readRegB;
    logic [31:0] data_readRegA;
    logic [31:0] data_readRegB;
    logic        ctrl_markBusy;
    logic [4:0]  ctrl_markReg;
    logic        busy_A;
    logic        busy_B;
    logic        busy_any;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state.
    logic [31:0] m_reg  [32];
    bit          m_busy [32];

    regfile_2r1w u_dut (
        .clock            (clock),
        .ctrl_reset_n     (ctrl_reset_n),
        .ctrl_writeEnable (ctrl_writeEnable),
        .ctrl_writeReg    (ctrl_writeReg),
        .data_writeReg    (data_writeReg),
        .ctrl_readRegA    (ctrl_readRegA),
        .ctrl_readRegB    (ctrl_readRegB),
        .data_readRegA    (data_readRegA),
        .data_readRegB    (data_readRegB),
        .ctrl_markBusy    (ctrl_markBusy),
        .ctrl_markReg     (ctrl_markReg),
        .busy_A           (busy_A),
        .busy_B           (busy_B),
        .busy_any         (busy_any)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic void model_reset();
        for (int i = 0; i < 32; i++) begin
            m_reg[i]  = 32'h0;
            m_busy[i] = 1'b0;
        end
    endfunction

    // Apply the inputs present at a rising edge to the model.
    function automatic void model_edge();
        if (ctrl_writeEnable && ctrl_writeReg != 5'd0) begin
            m_reg[ctrl_writeReg]  = data_writeReg;
            m_busy[ctrl_writeReg] = 1'b0;
        end
        if (ctrl_markBusy && ctrl_markReg != 5'd0) m_busy[ctrl_markReg] = 1'b1;
    endfunction

    function automatic bit fwd(input logic [4:0] a);
`ifdef REGFILE_BYPASS_EN
        return ctrl_writeEnable && ctrl_writeReg != 5'd0 && ctrl_writeReg == a;
`else
        return 1'b0 && (a == 5'd0);
`endif
    endfunction

    function automatic logic [31:0] exp_rd(input logic [4:0] a);
        if (fwd(a)) return data_writeReg;
        return m_reg[a];
    endfunction

    function automatic logic [31:0] exp_busy(input logic [4:0] a);
        if (fwd(a)) return {31'h0, ctrl_markBusy && ctrl_markReg == a};
        return {31'h0, m_busy[a]};
    endfunction

    function automatic logic [31:0] exp_any();
        bit any = 1'b0;
        for (int i = 0; i < 32; i++) any = any | m_busy[i];
        return {31'h0, any};
    endfunction

    task automatic check_all(input string tag);
        chk({tag, ".rdA"},  data_readRegA,        exp_rd(ctrl_readRegA));
        chk({tag, ".rdB"},  data_readRegB,        exp_rd(ctrl_readRegB));
        chk({tag, ".bA"},   {31'h0, busy_A},      exp_busy(ctrl_readRegA));
        chk({tag, ".bB"},   {31'h0, busy_B},      exp_busy(ctrl_readRegB));
        chk({tag, ".bany"}, {31'h0, busy_any},    exp_any());
    endtask

    // Advance one clock; inputs only ever change at posedge+1.
    task automatic tick();
        @(posedge clock);
        model_edge();
        #1;
    endtask

    task automatic idle();
        ctrl_writeEnable = 1'b0;
        ctrl_markBusy    = 1'b0;
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        ctrl_writeEnable = 1'b1;
        ctrl_writeReg    = a;
        data_writeReg    = d;
        tick();
        idle();
    endtask

    initial begin
        model_reset();
        // Hold reset across edges with a write pending: reset must win.
        ctrl_reset_n     = 1'b0;
        ctrl_writeEnable = 1'b1;
        ctrl_writeReg    = 5'd1;
        data_writeReg    = 32'hCAFEF00D;
        ctrl_readRegA    = 5'd1;
        ctrl_readRegB    = 5'd0;
        ctrl_markBusy    = 1'b1;
        ctrl_markReg     = 5'd2;
        @(posedge clock);
        @(posedge clock);
        #1;
        chk("rst_hold.rdA", data_readRegA, 32'h0);
        chk("rst_hold.bany", {31'h0, busy_any}, 32'h0);
        idle();
        ctrl_reset_n = 1'b1;
        #1;
        check_all("rst_idle");

        // Async reset mid-period clears r5 without a clock edge.
        wr(5'd5, 32'hDEADBEEF);
        ctrl_readRegA = 5'd5;
        #1;
        chk("pre_rst.r5", data_readRegA, 32'hDEADBEEF);
        ctrl_reset_n = 1'b0;
        model_reset();
        #1;
        chk("async_rst.r5", data_readRegA, 32'h0);
        #3;
        ctrl_reset_n = 1'b1;
        #1;
        check_all("post_rst");

        // Basic write/read and r0 hardwiring.
        wr(5'd7, 32'h12345678);
        ctrl_readRegA = 5'd7;
        ctrl_readRegB = 5'd7;
        #1;
        chk("r7.A", data_readRegA, 32'h12345678);
        chk("r7.B", data_readRegB, 32'h12345678);
        wr(5'd0, 32'hFFFFFFFF);
        ctrl_readRegA = 5'd0;
        #1;
        chk("r0.A", data_readRegA, 32'h0);

        // Full sweep.
        for (int i = 1; i < 32; i++) wr(5'(i), 32'(i) * 32'h01010101);
        for (int i = 0; i < 32; i++) begin
            ctrl_readRegA = 5'(i);
            ctrl_readRegB = 5'(31 - i);
            #1;
            chk("sweep.A", data_readRegA, 32'(i) * 32'h01010101);
            chk("sweep.B", data_readRegB, 32'(31 - i) * 32'h01010101);
        end

        // Same-cycle write/read hazard on r3.
        wr(5'd3, 32'hAAAA0000);
        ctrl_writeEnable = 1'b1;
        ctrl_writeReg    = 5'd3;
        data_writeReg    = 32'h5555FFFF;
        ctrl_readRegA    = 5'd3;
        #1;
`ifdef REGFILE_BYPASS_EN
        chk("hazard.same", data_readRegA, 32'h5555FFFF);
`else
        chk("hazard.same", data_readRegA, 32'hAAAA0000);
`endif
        tick();
        idle();
        #1;
        chk("hazard.next", data_readRegA, 32'h5555FFFF);

        // Scoreboard: mark, clear, mark+write same edge, mark r0.
        ctrl_readRegA = 5'd9;
        ctrl_readRegB = 5'd8;
        ctrl_markBusy = 1'b1;
        ctrl_markReg  = 5'd9;
        #1;
        chk("mark9.now", {31'h0, busy_A}, 32'h0);
        tick();
        idle();
        #1;
        chk("mark9.bA", {31'h0, busy_A}, 32'h1);
        chk("mark9.bany", {31'h0, busy_any}, 32'h1);
        chk("mark9.bB", {31'h0, busy_B}, 32'h0);
        wr(5'd9, 32'h00000099);
        #1;
        chk("clr9.bA", {31'h0, busy_A}, 32'h0);
        chk("clr9.bany", {31'h0, busy_any}, 32'h0);
        ctrl_markBusy = 1'b1;
        ctrl_markReg  = 5'd9;
        wr(5'd9, 32'h00000999);
        #1;
        chk("markwr9.bA", {31'h0, busy_A}, 32'h1);
        chk("markwr9.rd", data_readRegA, 32'h00000999);
        wr(5'd9, 32'h0);
        ctrl_markBusy = 1'b1;
        ctrl_markReg  = 5'd0;
        tick();
        idle();
        ctrl_readRegA = 5'd0;
        #1;
        chk("mark0.bany", {31'h0, busy_any}, 32'h0);
        chk("mark0.bA", {31'h0, busy_A}, 32'h0);

        // Randomized phase; narrow address range forces collisions.
        for (int n = 0; n < 400; n++) begin
            ctrl_writeEnable = ($urandom_range(0, 1) == 1);
            ctrl_writeReg    = 5'($urandom_range(0, 7));
            data_writeReg    = $urandom;
            ctrl_readRegA    = 5'($urandom_range(0, 7));
            ctrl_readRegB    = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 7));
            ctrl_markBusy    = ($urandom_range(0, 3) == 0);
            ctrl_markReg     = 5'($urandom_range(0, 7));
            #1;
            check_all("rand");
            tick();
        end
        idle();
        #1;
        check_all("final");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/regfile_2r1w.md
Name: regfile_2r1w

Overview:
- 32 x 32-bit processor register file with one synchronous write port and two read ports.
- Each read port is built from 32 instances of the existing bitwise 32:1 mux, one per data bit, with the 5-bit read address as the mux select.
- Includes a per-register busy scoreboard so the stall logic can detect reads of registers awaiting a multi-cycle (mult/div) result.
- Sits between writeback (upstream) and decode/operand fetch (downstream).

Parameters:
- DATA_W, 32, register width in bits; the read-mux bit-slice count equals DATA_W.
- NUM_REGS, 32, number of registers; fixed at 32 to match the 5-bit 32:1 mux select.

Ports:
- clock  input  1  single clock; all state updates on the rising edge.
- ctrl_reset_n  input  1  asynchronous, active-low reset.
- ctrl_writeEnable  input  1  write strobe.
- ctrl_writeReg  input  5  write address.
- data_writeReg  input  32  write data.
- ctrl_readRegA  input  5  read address, port A.
- ctrl_readRegB  input  5  read address, port B.
- data_readRegA  output  32  read data, port A.
- data_readRegB  output  32  read data, port B.
- ctrl_markBusy  input  1  sets the busy bit of ctrl_markReg.
- ctrl_markReg  input  5  register to mark busy (destination of an issued mult/div).
- busy_A  output  1  busy bit of ctrl_readRegA.
- busy_B  output  1  busy bit of ctrl_readRegB.
- busy_any  output  1  OR of all 32 busy bits.

Behaviour:
- Reset: while ctrl_reset_n = 0, all registers and busy bits clear to 0 immediately, independent of clock. Both read outputs are therefore 0, and busy_A, busy_B and busy_any are 0.
- Reset mid-write: reset wins; no write lands on the edge where reset is asserted.
- Write: on the rising edge, if ctrl_writeEnable = 1 and ctrl_writeReg != 0, then reg[ctrl_writeReg] <= data_writeReg. Write latency is 1 cycle.
- Register 0: hardwired to 0. Writes to it are silently dropped, and it is never marked busy.
- Read: combinational; data_readRegX = reg[ctrl_readRegX] through the 32:1 mux tree with 0 cycles of latency.
- Same-cycle write and read to the same register: the read returns the OLD value unless REGFILE_BYPASS_EN is defined.
- Ports A and B are fully independent and may address the same register.
- Scoreboard update on each rising edge:
  - ctrl_markBusy = 1 and ctrl_markReg != 0 sets busy[ctrl_markReg].
  - A committed write (ctrl_writeEnable = 1, ctrl_writeReg != 0) clears busy[ctrl_writeReg].
  - If the mark and the write target the same register on the same edge, mark wins and busy stays 1. This covers back-to-back issue to the same destination.
  - Marking an already-busy register is a no-op.
  - Clearing a non-busy register is a no-op.
- Busy outputs:
  - busy_A = busy[ctrl_readRegA] and busy_B = busy[ctrl_readRegB], both combinational.
  - Both are 0 when the address is 0.
- No other state. Undefined addresses cannot occur because the address width is exactly 5.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined: if ctrl_writeEnable = 1, ctrl_writeReg != 0 and ctrl_writeReg == ctrl_readRegX, then data_readRegX = data_writeReg in the same cycle (write-to-read forwarding). busy_X for that port also reads 0, unless the same register is being marked on that edge.
- Undefined: no forwarding; reads reflect the registered state only.

Test Plan:
- Reset: write 0xDEADBEEF to r5, pulse ctrl_reset_n low for half a cycle mid-period -> data_readRegA (addr 5) = 0 immediately, without waiting for a clock edge.
- Write/read: write 0x12345678 to r7, then the next cycle read A = 7 and B = 7 -> both read 0x12345678. Write 0xFFFFFFFF to r0 -> reading r0 returns 0.
- Full sweep: write reg[i] = i * 0x01010101 for i = 1..31, then read all pairs (i, 31 - i) -> every value matches and r0 reads 0.
- Same-cycle hazard: r3 = 0xAAAA0000; write 0x5555FFFF to r3 while reading A = 3 -> 0xAAAA0000 without the macro, 0x5555FFFF with REGFILE_BYPASS_EN. The next cycle reads 0x5555FFFF in both builds.
- Scoreboard:
  - Mark r9 -> busy_A (addr 9) = 1 and busy_any = 1 from the next cycle.
  - Write r9 -> busy clears the cycle after.
  - Mark and write r9 on the same edge -> busy stays 1.
  - Mark r0 -> busy_any stays 0.
